// File: rtl/mvau_wload_pkg.sv
// Shared types and helpers for the MVAU weight loader and its weight RAMs.
// A load visits every (address, PE) slot once, so its length is depth*pe beats.
package mvau_wload_pkg;

    typedef enum logic [1:0] {
        WL_IDLE = 2'd0,
        WL_LOAD = 2'd1,
        WL_DONE = 2'd2
    } wl_state_t;

    function automatic int wl_beats(input int depth, input int pe);
        return depth * pe;
    endfunction

endpackage

// File: rtl/mvau_weight_ram.sv
// One PE weight memory: single write port fed by the loader, registered read port
// with one cycle of latency, matching the original elaboration-time weight memory.
module mvau_weight_ram #(
    parameter int DW      = 2,
    parameter int DEPTH   = 4,
    parameter int ADDR_BW = 4
) (
    input  logic               aclk,
    input  logic               i_we,
    input  logic [ADDR_BW-1:0] i_waddr,
    input  logic [DW-1:0]      i_wdata,
    input  logic [ADDR_BW-1:0] i_raddr,
    output logic [DW-1:0]      o_rdata
);

    localparam int                 IDX_BW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_BW-1:0] ADDR_LAST = ADDR_BW'(DEPTH - 1);

    logic [DW-1:0]     r_mem [DEPTH];
    logic [DW-1:0]     r_rdata;
    logic [IDX_BW-1:0] w_widx;
    logic [IDX_BW-1:0] w_ridx;
    logic              w_wok;
    logic              w_rok;

    // Addresses beyond the last word are ignored on write and read back as zero.
    assign w_wok  = (i_waddr <= ADDR_LAST);
    assign w_rok  = (i_raddr <= ADDR_LAST);
    assign w_widx = i_waddr[IDX_BW-1:0];
    assign w_ridx = i_raddr[IDX_BW-1:0];

    always_ff @(posedge aclk) begin
        if (i_we && w_wok) begin
            r_mem[w_widx] <= i_wdata;
        end
        r_rdata <= w_rok ? r_mem[w_ridx] : '0;
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mvau_weight_loader.sv
// Accepts a weight stream and scatters word k to PE (k mod PE), address (k div PE),
// through one registered write port shared by all PE weight memories.
module mvau_weight_loader
    import mvau_wload_pkg::*;
#(
    parameter int SIMD         = 2,
    parameter int TW           = 1,
    parameter int PE           = 2,
    parameter int WMEM_DEPTH   = 4,
    parameter int WMEM_ADDR_BW = 4
) (
    input  logic                    aclk,
    input  logic                    rst,
    input  logic                    load_start,
    input  logic [SIMD*TW-1:0]      s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    output logic [PE-1:0]           wmem_we,
    output logic [WMEM_ADDR_BW-1:0] wmem_waddr,
    output logic [SIMD*TW-1:0]      wmem_wdata,
    output logic                    load_busy,
    output logic                    load_done,
    output logic                    load_err
);

    localparam int                      DW        = SIMD * TW;
    localparam int                      PE_BW     = (PE > 1) ? $clog2(PE) : 1;
    localparam logic [PE_BW-1:0]        PE_LAST   = PE_BW'(PE - 1);
    localparam logic [WMEM_ADDR_BW-1:0] ADDR_LAST = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

    wl_state_t               r_state;
    wl_state_t               w_state_next;
    logic [PE_BW-1:0]        r_pe_cnt;
    logic [WMEM_ADDR_BW-1:0] r_addr_cnt;
    logic [PE-1:0]           r_we;
    logic [WMEM_ADDR_BW-1:0] r_waddr;
    logic [DW-1:0]           r_wdata;
    logic                    r_err;

    logic                    w_tready;
    logic                    w_busy;
    logic                    w_done;
    logic                    w_start;
    logic                    w_beat;
    logic                    w_final;
    logic                    w_err_set;
    logic [PE-1:0]           w_we_dec;

    assign w_beat    = s_axis_tvalid & w_tready;
    assign w_final   = (r_pe_cnt == PE_LAST) && (r_addr_cnt == ADDR_LAST);
    // Framing is wrong when tlast disagrees with the slot position: early or missing.
    assign w_err_set = w_beat & (w_final ^ s_axis_tlast);

    for (genvar gi = 0; gi < PE; gi++) begin : g_we_dec
        assign w_we_dec[gi] = (r_pe_cnt == PE_BW'(gi));
    end

    always_comb begin
        w_state_next = r_state;
        w_tready     = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_start      = 1'b0;
        unique case (r_state)
            WL_IDLE: begin
                if (load_start) begin
                    w_start      = 1'b1;
                    w_state_next = WL_LOAD;
                end
            end
            WL_LOAD: begin
                w_tready = 1'b1;
                w_busy   = 1'b1;
                if (s_axis_tvalid && (w_final || s_axis_tlast)) begin
                    w_state_next = WL_DONE;
                end
            end
            WL_DONE: begin
                w_done = 1'b1;
                if (load_start) begin
                    w_start      = 1'b1;
                    w_state_next = WL_LOAD;
                end else begin
                    w_state_next = WL_IDLE;
                end
            end
            default: begin
                w_state_next = WL_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            r_state    <= WL_IDLE;
            r_pe_cnt   <= '0;
            r_addr_cnt <= '0;
            r_we       <= '0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_we    <= w_beat ? w_we_dec : '0;
            if (w_beat) begin
                r_waddr <= r_addr_cnt;
                r_wdata <= s_axis_tdata;
            end
            if (w_start) begin
                r_pe_cnt   <= '0;
                r_addr_cnt <= '0;
                r_err      <= 1'b0;
            end else if (w_beat) begin
                if (r_pe_cnt == PE_LAST) begin
                    r_pe_cnt   <= '0;
                    r_addr_cnt <= r_addr_cnt + WMEM_ADDR_BW'(1);
                end else begin
                    r_pe_cnt <= r_pe_cnt + PE_BW'(1);
                end
                if (w_err_set) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign s_axis_tready = w_tready;
    assign load_busy     = w_busy;
    assign load_done     = w_done;
    assign load_err      = r_err;
    assign wmem_we       = r_we;
    assign wmem_waddr    = r_waddr;
    assign wmem_wdata    = r_wdata;

endmodule

// File: tb/tb_mvau_weight_loader.sv
// Bench for the weight loader: a slot-counting model predicts every output each cycle,
// and two weight RAMs behind the write port are read back against literal contents.
// TW is 4 so that the word values used in the loads stay distinct in memory.
module tb_mvau_weight_loader;
    import mvau_wload_pkg::*;

    localparam int SIMD  = 2;
    localparam int TW    = 4;
    localparam int PE    = 2;
    localparam int DEPTH = 4;
    localparam int ABW   = 4;
    localparam int DW    = SIMD * TW;
    localparam int N     = wl_beats(DEPTH, PE);

    logic           aclk = 1'b0;
    logic           rst = 1'b1;
    logic           load_start = 1'b0;
    logic [DW-1:0]  s_axis_tdata = '0;
    logic           s_axis_tvalid = 1'b0;
    logic           s_axis_tready;
    logic           s_axis_tlast = 1'b0;
    logic [PE-1:0]  wmem_we;
    logic [ABW-1:0] wmem_waddr;
    logic [DW-1:0]  wmem_wdata;
    logic           load_busy;
    logic           load_done;
    logic           load_err;
    logic [ABW-1:0] r_raddr = '0;
    logic [DW-1:0]  rd [PE];

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int w0;

    // model state
    bit             m_loading = 0;
    bit             m_done = 0;
    bit             m_err = 0;
    bit             m_rst = 0;
    bit             m_last;
    int             m_k = 0;
    logic [PE-1:0]  m_we = '0;
    logic [ABW-1:0] m_addr = '0;
    logic [DW-1:0]  m_data = '0;
    logic [DW-1:0]  exp_mem [PE][DEPTH];

    always #5 aclk = ~aclk;

    mvau_weight_loader #(
        .SIMD(SIMD), .TW(TW), .PE(PE), .WMEM_DEPTH(DEPTH), .WMEM_ADDR_BW(ABW)
    ) dut (
        .aclk(aclk), .rst(rst), .load_start(load_start),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .wmem_we(wmem_we), .wmem_waddr(wmem_waddr), .wmem_wdata(wmem_wdata),
        .load_busy(load_busy), .load_done(load_done), .load_err(load_err)
    );

    for (genvar gi = 0; gi < PE; gi++) begin : g_ram
        mvau_weight_ram #(.DW(DW), .DEPTH(DEPTH), .ADDR_BW(ABW)) u_ram (
            .aclk(aclk), .i_we(wmem_we[gi]), .i_waddr(wmem_waddr),
            .i_wdata(wmem_wdata), .i_raddr(r_raddr), .o_rdata(rd[gi])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Model: word k of a load lands in PE k%PE at address k/PE one cycle after its beat.
    always @(posedge aclk) begin
        m_rst = rst;
        if (rst) begin
            m_loading = 0; m_done = 0; m_err = 0; m_k = 0;
            m_we = '0; m_addr = '0; m_data = '0;
        end else begin
            m_we = '0;
            if (m_loading) begin
                if (s_axis_tvalid) begin
                    m_we   = PE'(1) << (m_k % PE);
                    m_addr = ABW'(m_k / PE);
                    m_data = s_axis_tdata;
                    exp_mem[m_k % PE][m_k / PE] = s_axis_tdata;
                    m_last = (m_k == N - 1);
                    m_k++;
                    if (m_last || s_axis_tlast) begin
                        m_loading = 0;
                        m_done    = 1;
                        if (m_last != s_axis_tlast) m_err = 1;
                    end
                end
            end else if (load_start) begin
                m_loading = 1; m_done = 0; m_k = 0; m_err = 0;
            end else begin
                m_done = 0;
            end
        end
        #1;
        chk("tready", 32'(s_axis_tready), 32'(m_loading));
        chk("busy", 32'(load_busy), 32'(m_loading));
        chk("done", 32'(load_done), 32'(m_done));
        chk("err", 32'(load_err), 32'(m_err));
        chk("we", 32'(wmem_we), 32'(m_we));
        if (m_we != '0 || m_rst) begin
            chk("waddr", 32'(wmem_waddr), 32'(m_addr));
            chk("wdata", 32'(wmem_wdata), 32'(m_data));
        end
        if (wmem_we != '0) wr_count++;
    end

    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge aclk);
        load_start = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input bit last, input int gap);
        int n;
        s_axis_tvalid = 1'b0;
        repeat (gap) @(negedge aclk);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        n = 0;
        while (!s_axis_tready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual tready 0 required 1 at %0t", $time);
        end
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic rd_chk(input int p, input int a, input logic [DW-1:0] lit);
        r_raddr = ABW'(a);
        @(negedge aclk);
        chk($sformatf("ram_pe%0d_a%0d", p, a), 32'(rd[p]), 32'(lit));
        chk($sformatf("model_pe%0d_a%0d", p, a), 32'(exp_mem[p][a]), 32'(lit));
    endtask

    task automatic full_load(input int base, input bit gaps);
        int gap_tab [8] = '{0, 1, 2, 0, 1, 0, 3, 1};
        for (int k = 0; k < N; k++) begin
            send(DW'(base + k), (k == N - 1), gaps ? gap_tab[k] : 0);
        end
    endtask

    task automatic chk_ordered(input int base);
        for (int a = 0; a < DEPTH; a++) begin
            rd_chk(0, a, DW'(base + 2 * a));
            rd_chk(1, a, DW'(base + 2 * a + 1));
        end
    endtask

    initial begin
        #200000;
        checks++;
        errors++;
        $display("FAIL watchdog actual running required finished at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        repeat (3) @(negedge aclk);
        rst = 1'b0;
        @(negedge aclk);

        // full load, no gaps
        w0 = wr_count;
        pulse_start();
        full_load(0, 0);
        chk("t1_done", 32'(load_done), 32'd1);
        chk("t1_err", 32'(load_err), 32'd0);
        chk("t1_last_we", 32'(wmem_we), 32'h2);
        chk("t1_last_addr", 32'(wmem_waddr), 32'd3);
        chk("t1_last_data", 32'(wmem_wdata), 32'd7);
        @(negedge aclk);
        chk("t1_done_off", 32'(load_done), 32'd0);
        chk("t1_writes", 32'(wr_count - w0), 32'd8);
        chk_ordered(0);

        // same load with gaps
        w0 = wr_count;
        pulse_start();
        full_load(0, 1);
        repeat (2) @(negedge aclk);
        chk("t2_writes", 32'(wr_count - w0), 32'd8);
        chk_ordered(0);

        // early tlast on beat 4
        w0 = wr_count;
        pulse_start();
        for (int k = 0; k < 5; k++) send(DW'(8 + k), (k == 4), 0);
        chk("t3_done", 32'(load_done), 32'd1);
        chk("t3_err", 32'(load_err), 32'd1);
        @(negedge aclk);
        chk("t3_idle_busy", 32'(load_busy), 32'd0);
        chk("t3_writes", 32'(wr_count - w0), 32'd5);
        rd_chk(0, 0, 8); rd_chk(0, 1, 10); rd_chk(0, 2, 12); rd_chk(0, 3, 6);
        rd_chk(1, 0, 9); rd_chk(1, 1, 11); rd_chk(1, 2, 5); rd_chk(1, 3, 7);

        // missing tlast; a 9th word must be refused
        pulse_start();
        chk("t3_err_cleared", 32'(load_err), 32'd0);
        w0 = wr_count;
        for (int k = 0; k < N; k++) send(DW'(16 + k), 0, 0);
        chk("t4_done", 32'(load_done), 32'd1);
        chk("t4_err", 32'(load_err), 32'd1);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("t4_tready", 32'(s_axis_tready), 32'd0);
        end
        s_axis_tvalid = 1'b0;
        chk("t4_writes", 32'(wr_count - w0), 32'd8);

        // reset arriving together with beat 3
        w0 = wr_count;
        pulse_start();
        for (int k = 0; k < 3; k++) send(DW'(k), 0, 0);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'd3;
        rst = 1'b1;
        @(negedge aclk);
        rst = 1'b0;
        s_axis_tvalid = 1'b0;
        chk("t5_we", 32'(wmem_we), 32'd0);
        chk("t5_waddr", 32'(wmem_waddr), 32'd0);
        chk("t5_wdata", 32'(wmem_wdata), 32'd0);
        chk("t5_busy", 32'(load_busy), 32'd0);
        chk("t5_tready", 32'(s_axis_tready), 32'd0);
        chk("t5_writes", 32'(wr_count - w0), 32'd3);
        @(negedge aclk);
        pulse_start();
        full_load(0, 0);
        chk("t5_err", 32'(load_err), 32'd0);
        @(negedge aclk);
        chk_ordered(0);

        // start during LOAD ignored; start in DONE restarts
        pulse_start();
        for (int k = 0; k < 3; k++) send(DW'(8'h20 + k), 0, 0);
        pulse_start();
        for (int k = 3; k < N; k++) send(DW'(8'h20 + k), (k == N - 1), 0);
        chk("t6_done", 32'(load_done), 32'd1);
        pulse_start();
        chk("t6_busy", 32'(load_busy), 32'd1);
        send(8'h55, 0, 0);
        chk("t6_first_we", 32'(wmem_we), 32'd1);
        chk("t6_first_addr", 32'(wmem_waddr), 32'd0);
        chk("t6_first_data", 32'(wmem_wdata), 32'h55);
        for (int k = 1; k < N; k++) send(DW'(8'h55 + k), (k == N - 1), 0);
        @(negedge aclk);
        chk_ordered(8'h55);

        repeat (3) @(negedge aclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
